// File: rtl/input_failover_ctrl.sv
// Primary/fallback serial input selector for the smart-LED front end: qualifies in0 by edge activity,
// fails over to in1 on in0 idle, and only switches inside a both-low guard window. Optional FAILOVER_STATS_EN.
module input_failover_ctrl #(
    parameter int EDGE_QUAL = 64,
    parameter int TIMEOUT   = 4096,
    parameter int GUARD     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in0,
    input  logic       in1,
    input  logic       testmode,
    output logic       out,
    output logic       sel,
    output logic [1:0] state,
    output logic       switch_pulse
`ifdef FAILOVER_STATS_EN
    ,
    output logic [7:0] switch_count,
    output logic [7:0] abort_count
`endif
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int EW = $clog2(EDGE_QUAL + 1);
    localparam int GW = $clog2(GUARD + 1);

    localparam logic [1:0] S_IN1   = 2'd0;
    localparam logic [1:0] S_WAIT0 = 2'd1;
    localparam logic [1:0] S_IN0   = 2'd2;
    localparam logic [1:0] S_WAIT1 = 2'd3;

    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT);
    localparam logic [EW-1:0] EDGE_LAST  = EW'(EDGE_QUAL - 1);
    localparam logic [EW-1:0] EDGE_MAX   = EW'(EDGE_QUAL);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);
    localparam logic [GW-1:0] GUARD_MAX  = GW'(GUARD);

    logic [1:0]    r_state;
    logic          r_last_in0;
    logic [IW-1:0] r_idle_cnt;
    logic [EW-1:0] r_edge_cnt;
    logic [GW-1:0] r_guard_cnt;
    logic          r_out;
    logic          r_sel;
    logic          r_pulse;

    logic          w_rise;
    logic          w_any;
    logic          w_idle;
    logic          w_both_low;
    logic          w_in_wait;
    logic          w_guard_ok;
    logic          w_route;
    logic [1:0]    w_state_next;
    logic [EW-1:0] w_edge_next;
    logic          w_pulse_next;
    logic          w_abort;

    assign w_rise     = ~r_last_in0 & in0;
    assign w_any      = r_last_in0 ^ in0;
    // Fires once, on the TIMEOUT-th quiet cycle; the saturated counter keeps it from re-firing.
    assign w_idle     = (r_idle_cnt == IDLE_LAST) & ~w_any;
    assign w_both_low = ~in0 & ~in1;
    assign w_in_wait  = (r_state == S_WAIT0) | (r_state == S_WAIT1);
    assign w_guard_ok = (r_guard_cnt == GUARD_LAST) & w_both_low;
    assign w_route    = ((r_state == S_IN0) | (r_state == S_WAIT1)) ^ testmode;

    always_comb begin
        w_state_next = r_state;
        w_edge_next  = r_edge_cnt;
        w_pulse_next = 1'b0;
        w_abort      = 1'b0;
        if (w_rise && ((r_state == S_IN1) || (r_state == S_WAIT0)) && (r_edge_cnt != EDGE_MAX))
            w_edge_next = r_edge_cnt + 1'b1;
        case (r_state)
            S_IN1: begin
                if (w_rise && (r_edge_cnt == EDGE_LAST))
                    w_state_next = S_WAIT0;
                else if (w_idle)
                    w_edge_next = '0;
            end
            S_WAIT0: begin
                if (w_idle) begin
                    w_state_next = S_IN1;
                    w_edge_next  = '0;
                    w_abort      = 1'b1;
                end else if (w_guard_ok) begin
                    w_state_next = S_IN0;
                    w_pulse_next = 1'b1;
                end
            end
            S_IN0: begin
                if (w_idle)
                    w_state_next = S_WAIT1;
            end
            default: begin
                if (w_rise) begin
                    w_state_next = S_IN0;
                end else if (w_guard_ok) begin
                    w_state_next = S_IN1;
                    w_pulse_next = 1'b1;
                    w_edge_next  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IN1;
            r_last_in0  <= 1'b0;
            r_idle_cnt  <= '0;
            r_edge_cnt  <= '0;
            r_guard_cnt <= '0;
            r_out       <= 1'b0;
            r_sel       <= 1'b0;
            r_pulse     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_last_in0 <= in0;
            r_edge_cnt <= w_edge_next;
            r_pulse    <= w_pulse_next;
            r_out      <= w_route ? in0 : in1;
            r_sel      <= w_route;
            if (w_any)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != IDLE_MAX)
                r_idle_cnt <= r_idle_cnt + 1'b1;
            if (!w_in_wait || !w_both_low)
                r_guard_cnt <= '0;
            else if (r_guard_cnt != GUARD_MAX)
                r_guard_cnt <= r_guard_cnt + 1'b1;
        end
    end

    assign out          = r_out;
    assign sel          = r_sel;
    assign state        = r_state;
    assign switch_pulse = r_pulse;

`ifdef FAILOVER_STATS_EN
    logic [7:0] r_switch_cnt;
    logic [7:0] r_abort_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_switch_cnt <= '0;
            r_abort_cnt  <= '0;
        end else begin
            if (w_pulse_next && (r_switch_cnt != 8'hFF))
                r_switch_cnt <= r_switch_cnt + 1'b1;
            if (w_abort && (r_abort_cnt != 8'hFF))
                r_abort_cnt <= r_abort_cnt + 1'b1;
        end
    end

    assign switch_count = r_switch_cnt;
    assign abort_count  = r_abort_cnt;
`endif

endmodule

// File: tb/tb_input_failover_ctrl.sv
// Directed bench for input_failover_ctrl (EDGE_QUAL=4, TIMEOUT=32, GUARD=4) with a run-length based
// reference model checked every cycle, plus literal spot checks that pin the model.
module tb_input_failover_ctrl;

    localparam int EDGE_QUAL = 4;
    localparam int TIMEOUT   = 32;
    localparam int GUARD     = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in0;
    logic       in1;
    logic       testmode;
    logic       out;
    logic       sel;
    logic [1:0] state;
    logic       switch_pulse;
`ifdef FAILOVER_STATS_EN
    logic [7:0] switch_count;
    logic [7:0] abort_count;
`endif

    input_failover_ctrl #(
        .EDGE_QUAL(EDGE_QUAL),
        .TIMEOUT  (TIMEOUT),
        .GUARD    (GUARD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in0         (in0),
        .in1         (in1),
        .testmode    (testmode),
        .out         (out),
        .sel         (sel),
        .state       (state),
        .switch_pulse(switch_pulse)
`ifdef FAILOVER_STATS_EN
        ,
        .switch_count(switch_count),
        .abort_count (abort_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: run lengths of quiet in0 and both-low cycles, plus a count of recent rises.
    int m_state, quiet, rises, bothlow, m_sw, m_ab;
    bit m_last, m_out, m_sel, m_pulse;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic spot(input string name, input logic [7:0] act, input logic [7:0] exp);
        $display("spot %s: got %0h expected %0h", name, act, exp);
        check(name, act, exp);
    endtask

    task automatic model_update();
        bit route, rise, edge_any, idle, gdone;
        if (!rst_n) begin
            m_state = 0; quiet = 0; rises = 0; bothlow = 0;
            m_last = 0; m_out = 0; m_sel = 0; m_pulse = 0;
            m_sw = 0; m_ab = 0;
        end else begin
            route    = ((m_state == 2) || (m_state == 3)) ^ testmode;
            m_out    = route ? in0 : in1;
            m_sel    = route;
            rise     = in0 & ~m_last;
            edge_any = in0 ^ m_last;
            m_last   = in0;
            quiet    = edge_any ? 0 : quiet + 1;
            idle     = (quiet == TIMEOUT);
            if (m_state == 1 || m_state == 3)
                bothlow = (!in0 && !in1) ? bothlow + 1 : 0;
            else
                bothlow = 0;
            gdone   = (bothlow == GUARD);
            m_pulse = 0;
            case (m_state)
                0: begin
                    if (rise) begin
                        rises++;
                        if (rises >= EDGE_QUAL) m_state = 1;
                    end
                    if (idle) rises = 0;
                end
                1: begin
                    if (idle) begin
                        m_state = 0; rises = 0;
                        if (m_ab < 255) m_ab++;
                    end else if (gdone) begin
                        m_state = 2; m_pulse = 1;
                    end
                end
                2: if (idle) m_state = 3;
                default: begin
                    if (rise) m_state = 2;
                    else if (gdone) begin
                        m_state = 0; m_pulse = 1; rises = 0;
                    end
                end
            endcase
            if (m_pulse && m_sw < 255) m_sw++;
        end
    endtask

    task automatic step(input logic a, input logic b);
        in0 = a;
        in1 = b;
        @(posedge clk);
        model_update();
        #1;
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("out", {7'd0, out}, {7'd0, m_out});
            check("sel", {7'd0, sel}, {7'd0, m_sel});
            check("state", {6'd0, state}, 8'(m_state));
            check("switch_pulse", {7'd0, switch_pulse}, {7'd0, m_pulse});
`ifdef FAILOVER_STATS_EN
            check("switch_count", switch_count, 8'(m_sw));
            check("abort_count", abort_count, 8'(m_ab));
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        testmode = 1'b0;
        in0 = 1'b0;
        in1 = 1'b1;

        // Reset with in1 high, then release.
        repeat (3) step(0, 1);
        spot("rst_out", {7'd0, out}, 8'd0);
        spot("rst_sel", {7'd0, sel}, 8'd0);
        spot("rst_state", {6'd0, state}, 8'd0);
        spot("rst_pulse", {7'd0, switch_pulse}, 8'd0);
        rst_n = 1'b1;
        step(0, 1);
        spot("release_out", {7'd0, out}, 8'd1);

        // Qualify in0 with 4 pulses, then switch after the guard window.
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            if (i == 3) spot("qual_state", {6'd0, state}, 8'd1);
            step(1, 0);
            step(0, 0);
            step(0, 0);
        end
        step(0, 0);
        spot("guard3_state", {6'd0, state}, 8'd1);
        spot("guard3_pulse", {7'd0, switch_pulse}, 8'd0);
        step(0, 0);
        spot("sw0_state", {6'd0, state}, 8'd2);
        spot("sw0_pulse", {7'd0, switch_pulse}, 8'd1);
        step(1, 0);
        spot("in0_sel", {7'd0, sel}, 8'd1);
        spot("in0_out_hi", {7'd0, out}, 8'd1);
        spot("in0_pulse_drop", {7'd0, switch_pulse}, 8'd0);
        step(0, 0);
        spot("in0_out_lo", {7'd0, out}, 8'd0);

        // in0 goes quiet while in1 toggles; fail back after the guard.
        for (int i = 1; i <= 31; i++) step(0, 1'(i % 2));
        spot("quiet31_state", {6'd0, state}, 8'd2);
        step(0, 0);
        spot("wait1_state", {6'd0, state}, 8'd3);
        step(0, 1);
        repeat (3) step(0, 0);
        spot("wait1_guard3", {6'd0, state}, 8'd3);
        step(0, 0);
        spot("sw1_state", {6'd0, state}, 8'd0);
        spot("sw1_pulse", {7'd0, switch_pulse}, 8'd1);
        step(0, 1);
        spot("in1_sel", {7'd0, sel}, 8'd0);
        spot("in1_out", {7'd0, out}, 8'd1);
`ifdef FAILOVER_STATS_EN
        spot("switch_count2", switch_count, 8'd2);
`endif

        // Stale edges are forgotten after an idle period.
        repeat (3) begin step(1, 1); step(0, 1); end
        repeat (32) step(0, 1);
        step(1, 1);
        step(0, 1);
        spot("stale_state", {6'd0, state}, 8'd0);
        repeat (2) begin step(1, 1); step(0, 1); end
        step(1, 1);
        spot("requal_state", {6'd0, state}, 8'd1);

        // Into IN0, then WAIT1, then in0 recovers before the guard completes.
        repeat (4) step(0, 0);
        spot("sw2_state", {6'd0, state}, 8'd2);
        repeat (29) step(0, 1);
        spot("wait1b_state", {6'd0, state}, 8'd3);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        spot("recover_state", {6'd0, state}, 8'd2);
        spot("recover_pulse", {7'd0, switch_pulse}, 8'd0);
        spot("recover_sel", {7'd0, sel}, 8'd1);
        step(0, 0);
        spot("recover_sel2", {7'd0, sel}, 8'd1);

        // Back to IN1, exercise testmode, then reset from WAIT0.
        repeat (32) step(0, 1);
        repeat (4) step(0, 0);
        spot("sw3_state", {6'd0, state}, 8'd0);
        step(0, 0);
        testmode = 1'b1;
        step(1, 0);
        spot("tm_sel", {7'd0, sel}, 8'd1);
        spot("tm_out", {7'd0, out}, 8'd1);
        spot("tm_state", {6'd0, state}, 8'd0);
        testmode = 1'b0;
        step(0, 0);
        spot("tm_off_sel", {7'd0, sel}, 8'd0);
        repeat (3) begin step(1, 0); step(0, 0); end
        spot("wait0_state", {6'd0, state}, 8'd1);
        rst_n = 1'b0;
        step(0, 0);
        spot("rst2_state", {6'd0, state}, 8'd0);
        spot("rst2_out", {7'd0, out}, 8'd0);
        spot("rst2_sel", {7'd0, sel}, 8'd0);
        spot("rst2_pulse", {7'd0, switch_pulse}, 8'd0);
        rst_n = 1'b1;
        step(0, 1);

        // WAIT0 aborts when in0 idles before a guard window appears.
        repeat (4) begin step(1, 1); step(0, 1); end
        repeat (31) step(0, 1);
        spot("pre_abort_state", {6'd0, state}, 8'd1);
        step(0, 1);
        spot("abort_state", {6'd0, state}, 8'd0);
        spot("abort_pulse", {7'd0, switch_pulse}, 8'd0);
`ifdef FAILOVER_STATS_EN
        spot("abort_count1", abort_count, 8'd1);
`endif
        step(0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_failover_ctrl.md
Name: input_failover_ctrl

Overview:
Controller that sequences the choice between the primary daisy-chain data input (in0) and the fallback input (in1) of the smart-LED front end.
- Qualifies in0 by counting recent rising edges.
- Fails over to in1 when the selected in0 goes idle.
- Switches only in a bus-idle guard window, so no LED frame is cut mid-bit.
- Sits between the pad inputs and the bit decoder; exports routing, state and switch events to status logic.

Parameters:
EDGE_QUAL, 64, in0 rising edges required to qualify in0 (>=1)
TIMEOUT, 4096, consecutive cycles with no in0 edge (either direction) that mark in0 idle (>=2)
GUARD, 16, consecutive cycles with in0 and in1 both low required before any switch (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in0  in  1  primary serial input, already synchronised
in1  in  1  fallback serial input, already synchronised
testmode  in  1  high: invert the routing decision
out  out  1  registered forwarded data
sel  out  1  registered; 1 = out carries in0, 0 = out carries in1
state  out  2  current FSM state: 0 IN1, 1 WAIT0, 2 IN0, 3 WAIT1
switch_pulse  out  1  one-cycle pulse when the FSM commits a switch

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IN1; out=0, sel=0, switch_pulse=0.
  - edge_cnt, idle_cnt, guard_cnt and last_in0 cleared.
  - Reset during any state returns to IN1 on the next edge.
- Edge detect:
  - rise = !last_in0 & in0; any = last_in0 ^ in0; last_in0 <= in0 every cycle.
- idle_cnt (width clog2(TIMEOUT+1), saturating at TIMEOUT):
  - cleared on any, else +1.
  - idle = (idle_cnt == TIMEOUT-1) & !any, i.e. the TIMEOUT-th quiet cycle.
- edge_cnt (saturating at EDGE_QUAL):
  - +1 on rise in IN1/WAIT0.
  - Cleared on idle in IN1 (edges must be recent) and on every entry to IN1.
- guard_cnt:
  - In WAIT0/WAIT1: +1 while in0==0 & in1==0; cleared when either input is high.
  - Cleared in IN0/IN1.
  - guard_ok = (guard_cnt == GUARD-1) & !in0 & !in1.
- Transitions (priority top-down within each state):
  - IN1: rise making edge_cnt reach EDGE_QUAL -> WAIT0. A rise on the same cycle as idle cannot occur, because any clears idle.
  - WAIT0: idle -> IN1 (abort, edge_cnt cleared); guard_ok -> IN0 with switch_pulse=1.
  - IN0: idle -> WAIT1.
  - WAIT1: rise -> IN0 (in0 recovered, no pulse, guard cleared); guard_ok -> IN1 with switch_pulse=1, edge_cnt cleared.
- Routing:
  - route = (state in {IN0, WAIT1}) XOR testmode, using the current (pre-update) state.
  - out <= route ? in0 : in1; sel <= route. Latency is 1 cycle.
  - After a switch, sel/out change on the cycle after switch_pulse.
- testmode:
  - Affects routing only; FSM and counters are unaffected.
  - Toggling testmode takes effect on the next cycle, with no guard window.
- switch_pulse:
  - High for exactly one cycle per committed switch; never high in consecutive cycles.

Optional Feature:
Macro FAILOVER_STATS_EN.
- Defined:
  - Adds output switch_count (8 bits): increments on every switch_pulse, saturates at 255, resets to 0.
  - Adds output abort_count (8 bits): increments on each WAIT0->IN1 abort, saturates at 255, resets to 0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use EDGE_QUAL=4, TIMEOUT=32, GUARD=4.
1. Hold rst_n=0 for 3 cycles with in1=1 -> out=0, sel=0, state=0, switch_pulse=0. Release -> out=1 one cycle later.
2. Drive 4 in0 pulses (2 high / 2 low), then in0=in1=0 -> state=1 after the 4th rise. state=2 and switch_pulse=1 on the 4th both-low cycle. sel=1 next cycle; out then mirrors in0 delayed by 1 cycle.
3. From IN0, hold in0=0 while in1 toggles -> state=3 on the 32nd quiet cycle. Switch to IN1 only after 4 consecutive both-low cycles, with switch_pulse=1, then sel=0.
4. In IN1: 3 in0 rises, 32 quiet cycles, then 1 rise -> state stays 0 (edge_cnt cleared by idle). 3 more rises -> state=1.
5. In WAIT1, give an in0 rise before the guard completes -> state=2, no switch_pulse, sel stays 1.
6. Set testmode=1 in IN1 -> sel=1 and out=in0 next cycle, state unchanged. Assert rst_n=0 while in WAIT0 -> state=0 and all outputs 0 next cycle. With FAILOVER_STATS_EN, check switch_count=2 after scenarios 2+3.
